// File: rtl/multi_blocker.sv
// multi_blocker: shared-pool-drain blocking window gating per-channel ack&trig into registered block outputs,
// with optional post-window cooldown and per-channel saturating block-edge counters.
module multi_blocker #(
    parameter int NUM_CH          = 4,
    parameter int SLOT_COUNT      = 8,
    parameter int TIMEOUT_W       = 6,
    parameter int COOLDOWN_CYCLES = 0,
    parameter int CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SLOT_COUNT-1:0]   slot_valid,
    input  logic                    stall,
    input  logic [NUM_CH-1:0]       ack,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       cfg_sticky,
    input  logic [TIMEOUT_W-1:0]    cfg_timeout,
    input  logic                    cnt_clr,
    output logic [NUM_CH-1:0]       block,
    output logic                    window_active,
    output logic                    expire,
    output logic [NUM_CH*CNT_W-1:0] block_cnt
);
    typedef enum logic [1:0] {IDLE, WINDOW, COOLDOWN} state_t;
    state_t state, state_nxt;
    logic [TIMEOUT_W-1:0] cnt, cnt_nxt, lim, lim_nxt;
    logic [NUM_CH-1:0] req, block_nxt;
    logic expire_nxt, in_win;
    assign req = ch_en & ack & trig;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lim   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lim   <= lim_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lim_nxt   = lim;
        case (state)
            IDLE: if (slot_valid == '0) begin
                state_nxt = WINDOW;
                cnt_nxt   = '0;
                lim_nxt   = cfg_timeout;
            end
            WINDOW: if (cnt < lim) begin
                cnt_nxt = cnt + {{(TIMEOUT_W-1){1'b0}}, ~stall};
            end else begin
                cnt_nxt   = '0;
                state_nxt = COOLDOWN_CYCLES > 0 ? COOLDOWN : IDLE;
            end
            COOLDOWN: if (int'(cnt) == COOLDOWN_CYCLES - 1) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + TIMEOUT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end
    // sticky hold is masked by ch_en so disabling a channel clears it on the next edge
    always_comb begin
        in_win     = state == WINDOW && cnt < lim;
        expire_nxt = state == WINDOW && cnt >= lim;
        block_nxt  = state == IDLE ? (slot_valid == '0 ? req : '0)
                   : in_win ? (req | (block & cfg_sticky & ch_en)) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            block         <= '0;
            window_active <= 1'b0;
            expire        <= 1'b0;
            block_cnt     <= '0;
        end else begin
            block         <= block_nxt;
            window_active <= state_nxt == WINDOW;
            expire        <= expire_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_clr)
                    block_cnt[i*CNT_W +: CNT_W] <= '0;
                else if (block_nxt[i] && !block[i] && !(&block_cnt[i*CNT_W +: CNT_W]))
                    block_cnt[i*CNT_W +: CNT_W] <= block_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_multi_blocker.sv
// tb_multi_blocker: directed checks of window timing, stall, sticky, cooldown, reset abort and counters.
module tb_multi_blocker;
    logic clk = 1'b0, rst, stall, cnt_clr;
    logic [7:0] slot_valid;
    logic [3:0] ack, trig, ch_en, cfg_sticky;
    logic [5:0] cfg_timeout;
    logic [3:0] block, block_c;
    logic window_active, wa_c, expire, expire_c;
    logic [31:0] block_cnt, block_cnt_c;
    int checks = 0, errors = 0;
    int hi0, hi1, exp_n, exp_at, overlap = 0;
    logic [6:0] bc, ec, wc;

    always #5 clk = ~clk;

    multi_blocker dut (
        .clk(clk), .rst(rst), .slot_valid(slot_valid), .stall(stall), .ack(ack), .trig(trig),
        .ch_en(ch_en), .cfg_sticky(cfg_sticky), .cfg_timeout(cfg_timeout), .cnt_clr(cnt_clr),
        .block(block), .window_active(window_active), .expire(expire), .block_cnt(block_cnt));

    multi_blocker #(.COOLDOWN_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst), .slot_valid(slot_valid), .stall(stall), .ack(ack), .trig(trig),
        .ch_en(ch_en), .cfg_sticky(cfg_sticky), .cfg_timeout(cfg_timeout), .cnt_clr(cnt_clr),
        .block(block_c), .window_active(wa_c), .expire(expire_c), .block_cnt(block_cnt_c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // runs n cycles of a window already requested via slot_valid=0; stall for 3 cycles from s0, req[1] pulse at p1
    task automatic observe(input int n, input int s0, input int p1);
        logic [5:0] t;
        t = cfg_timeout;
        hi0 = 0; hi1 = 0; exp_n = 0; exp_at = 0;
        for (int i = 1; i <= n; i++) begin
            tick;
            if (block[0]) hi0++;
            if (block[1]) hi1++;
            if (expire) begin exp_n++; exp_at = i; end
            if (expire && window_active) overlap++;
            if (i == 1) begin slot_valid = '1; cfg_timeout = 6'd1; end
            stall = (i >= s0 && i < s0 + 3);
            ack[1] = (i == p1);
            trig[1] = (i == p1);
        end
        cfg_timeout = t;
        stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; cnt_clr = 1'b0; slot_valid = '1;
        ack = '0; trig = '0; ch_en = '1; cfg_sticky = '0; cfg_timeout = 6'd4;
        tick; tick;
        rst = 1'b0;
        chk("rst_block", {28'd0, block}, 0);
        chk("rst_wa", {31'd0, window_active}, 0);
        chk("rst_expire", {31'd0, expire}, 0);
        chk("rst_cnt", block_cnt, 0);

        // cooldown instance: T=1, pool held empty
        cfg_timeout = 6'd1; ack[0] = 1'b1; trig[0] = 1'b1; slot_valid = '0;
        for (int i = 1; i <= 7; i++) begin
            tick;
            bc[i-1] = block_c[0];
            ec[i-1] = expire_c;
            wc[i-1] = wa_c;
        end
        chk("cd_block", {25'd0, bc}, 32'b1000011);
        chk("cd_expire", {25'd0, ec}, 32'b0000100);
        chk("cd_wa", {25'd0, wc}, 32'b1000011);
        chk("cd_cnt", {24'd0, block_cnt_c[7:0]}, 2);
        slot_valid = '1; rst = 1'b1; tick; rst = 1'b0; tick;

        cfg_timeout = 6'd4; slot_valid = '0;
        observe(9, 100, 0);
        chk("t4_hi", hi0, 5);
        chk("t4_exp_n", exp_n, 1);
        chk("t4_exp_at", exp_at, 6);
        chk("t4_cnt", {24'd0, block_cnt[7:0]}, 1);

        slot_valid = '0;
        observe(11, 2, 0);
        chk("stall_hi", hi0, 8);
        chk("stall_exp_at", exp_at, 9);
        chk("stall_exp_n", exp_n, 1);
        chk("stall_cnt", {24'd0, block_cnt[7:0]}, 2);

        cfg_sticky = 4'b0010; slot_valid = '0;
        observe(8, 100, 2);
        chk("sticky_hi1", hi1, 3);
        cfg_sticky = 4'b0000; slot_valid = '0;
        observe(8, 100, 2);
        chk("level_hi1", hi1, 1);

        cfg_sticky = 4'b0010; ack[1] = 1'b1; trig[1] = 1'b1; slot_valid = '0;
        tick;
        chk("dis_set", {31'd0, block[1]}, 1);
        ack[1] = 1'b0; trig[1] = 1'b0; slot_valid = '1;
        tick;
        chk("dis_hold", {31'd0, block[1]}, 1);
        ch_en[1] = 1'b0;
        tick;
        chk("dis_clear", {31'd0, block[1]}, 0);
        ch_en = '1;
        tick;
        chk("dis_stay", {31'd0, block[1]}, 0);
        tick; tick;
        chk("dis_expire", {31'd0, expire}, 1);
        tick;
        chk("dis_idle", {30'd0, window_active, expire}, 0);
        cfg_sticky = '0;

        cfg_timeout = 6'd0; slot_valid = '0;
        observe(4, 100, 0);
        chk("t0_hi", hi0, 1);
        chk("t0_exp_at", exp_at, 2);

        cfg_timeout = 6'd10; slot_valid = '0;
        tick;
        slot_valid = '1;
        chk("abort_wa", {31'd0, window_active}, 1);
        tick; tick;
        rst = 1'b1;
        tick;
        chk("abort_block", {28'd0, block}, 0);
        chk("abort_wa0", {31'd0, window_active}, 0);
        chk("abort_expire", {31'd0, expire}, 0);
        chk("abort_cnt", block_cnt, 0);
        rst = 1'b0;
        tick;
        chk("abort_noexp", {31'd0, expire}, 0);

        ack = 4'b0100; trig = '0; cfg_timeout = 6'd20;
        slot_valid = '0;
        for (int i = 1; i <= 5; i++) begin
            trig[2] = (i % 2 == 1);
            tick;
        end
        trig = '0; slot_valid = '1;
        tick;
        chk("cnt3", {24'd0, block_cnt[23:16]}, 3);
        slot_valid = '0;
        for (int i = 0; i < 1000; i++) begin
            trig[2] = ~trig[2];
            tick;
        end
        chk("cnt_sat", {24'd0, block_cnt[23:16]}, 255);
        trig = '0; slot_valid = '1;
        repeat (70) tick;
        chk("cnt_idle", {31'd0, window_active}, 0);
        slot_valid = '0; trig[2] = 1'b1; cnt_clr = 1'b1;
        tick;
        chk("clr_edge_block", {31'd0, block[2]}, 1);
        chk("clr_edge_cnt", {24'd0, block_cnt[23:16]}, 0);
        cnt_clr = 1'b0; trig = '0; slot_valid = '1;
        tick;
        chk("clr_after", {24'd0, block_cnt[23:16]}, 0);
        chk("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
